// File: rtl/sha3_pkg.sv
// sha3_pkg: shared types and helpers for the SHA3 absorb controller.
// Contents: rate-mode enum, absorb FSM state enum, rate-in-words helper.
package sha3_pkg;

    localparam int RATE_MAX_W = 1152;
    localparam int RATE_MAX_B = RATE_MAX_W / 8;
    localparam int WORD_W     = 64;

    typedef enum logic [1:0] {
        M576  = 2'b00,
        M832  = 2'b01,
        M1088 = 2'b11,
        M1152 = 2'b10
    } sha3_mode_e;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ABSORB = 3'd1,
        ST_PAD    = 3'd2,
        ST_PERM   = 3'd3,
        ST_DONE   = 3'd4
    } absorb_state_e;

    // Rate of the selected mode in 64-bit words.
    function automatic logic [4:0] rate_words(input logic [1:0] mode);
        logic [4:0] r;
        case (sha3_mode_e'(mode))
            M576:    r = 5'd9;
            M832:    r = 5'd13;
            M1088:   r = 5'd17;
            default: r = 5'd18;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sha3_pad_gen.sv
// sha3_pad_gen: combinational SHA3 padding of one rate block.
// Ports: block_i (raw block), mode_i (rate mode), p_i (first byte after data),
//        padded_o (block with tail zeroed, 0x06 at p_i, 0x80 at last rate byte).
module sha3_pad_gen
    import sha3_pkg::*;
(
    input  logic [RATE_MAX_W-1:0] block_i,
    input  logic [1:0]            mode_i,
    input  logic [7:0]            p_i,
    output logic [RATE_MAX_W-1:0] padded_o
);

    always_comb begin
        int         w_rb;
        int         w_p;
        logic [7:0] w_b;
        padded_o = '0;
        w_rb     = 8 * int'(rate_words(mode_i));
        w_p      = int'(p_i);
        w_b      = 8'h00;
        // p never exceeds the last rate byte, so k >= p also clears
        // everything beyond the rate.
        for (int k = 0; k < RATE_MAX_B; k++) begin
            w_b = (k < w_p) ? block_i[RATE_MAX_W-1-8*k -: 8] : 8'h00;
            if (k == w_p) begin
                w_b = w_b | 8'h06;
            end
            if (k == w_rb - 1) begin
                w_b = w_b | 8'h80;
            end
            padded_o[RATE_MAX_W-1-8*k -: 8] = w_b;
        end
    end

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// sha3_absorb_ctrl: SHA3 absorb sequencer. Packs 64-bit message words into
// rate blocks, pads the tail, and runs one Keccak-f permutation per block.
// Ports: clk/rst (sync, active high); start_i/mode_i begin a message;
//        msg_* stream in; block_o/mode_o feed the mapper; perm_start_o,
//        perm_first_o, perm_done_i talk to the core; busy_o, done_o, blk_cnt_o.
// Option: define SHA3_ABSORB_BLKCNT_EN to enable the saturating block counter.
module sha3_absorb_ctrl
    import sha3_pkg::*;
#(
    parameter int BUF_W = 1152,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_i,
    input  logic [1:0]       mode_i,
    input  logic             msg_valid_i,
    output logic             msg_ready_o,
    input  logic [63:0]      msg_data_i,
    input  logic             msg_last_i,
    input  logic [3:0]       msg_bytes_i,
    output logic [BUF_W-1:0] block_o,
    output logic [1:0]       mode_o,
    output logic             perm_start_o,
    output logic             perm_first_o,
    input  logic             perm_done_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [CNT_W-1:0] blk_cnt_o
);

    absorb_state_e    r_state;
    absorb_state_e    w_state_nx;
    logic [BUF_W-1:0] r_buf;
    logic [4:0]       r_wc;
    logic [7:0]       r_p;
    logic [1:0]       r_mode;
    logic             r_first;
    logic             r_final;
    logic             r_pad_pend;
    logic             r_issued;

    logic [3:0]       w_bytes;
    logic [4:0]       w_wc_nx;
    logic             w_full;
    logic             w_tail_full;
    logic [BUF_W-1:0] w_padded;

    assign w_bytes     = (msg_bytes_i > 4'd8) ? 4'd8 : msg_bytes_i;
    assign w_wc_nx     = r_wc + 5'd1;
    assign w_full      = (w_wc_nx == rate_words(r_mode));
    // Last word fills the block exactly: padding needs a fresh block.
    assign w_tail_full = msg_last_i && (w_bytes == 4'd8) && w_full;

    sha3_pad_gen u_pad (
        .block_i  (r_buf),
        .mode_i   (r_mode),
        .p_i      (r_p),
        .padded_o (w_padded)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        msg_ready_o  = 1'b0;
        perm_start_o = 1'b0;
        perm_first_o = 1'b0;
        busy_o       = 1'b1;
        done_o       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy_o = 1'b0;
                if (start_i) begin
                    w_state_nx = ST_ABSORB;
                end
            end
            ST_ABSORB: begin
                msg_ready_o = 1'b1;
                if (msg_valid_i) begin
                    if (msg_last_i && !w_tail_full) begin
                        w_state_nx = ST_PAD;
                    end else if (w_full) begin
                        w_state_nx = ST_PERM;
                    end
                end
            end
            ST_PAD: begin
                w_state_nx = ST_PERM;
            end
            ST_PERM: begin
                perm_start_o = !r_issued;
                perm_first_o = !r_issued && r_first;
                if (perm_done_i) begin
                    if (r_final) begin
                        w_state_nx = ST_DONE;
                    end else if (r_pad_pend) begin
                        w_state_nx = ST_PAD;
                    end else begin
                        w_state_nx = ST_ABSORB;
                    end
                end
            end
            ST_DONE: begin
                done_o     = 1'b1;
                w_state_nx = ST_IDLE;
            end
            default: begin
                w_state_nx = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_buf      <= '0;
            r_wc       <= '0;
            r_p        <= '0;
            r_mode     <= '0;
            r_first    <= 1'b0;
            r_final    <= 1'b0;
            r_pad_pend <= 1'b0;
            r_issued   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start_i) begin
                        r_mode     <= mode_i;
                        r_first    <= 1'b1;
                        r_final    <= 1'b0;
                        r_pad_pend <= 1'b0;
                        r_issued   <= 1'b0;
                        r_wc       <= '0;
                        r_buf      <= '0;
                    end
                end
                ST_ABSORB: begin
                    if (msg_valid_i) begin
                        for (int s = 0; s < BUF_W / WORD_W; s++) begin
                            if (r_wc == 5'(s)) begin
                                r_buf[BUF_W-1-WORD_W*s -: WORD_W] <= msg_data_i;
                            end
                        end
                        r_wc <= w_wc_nx;
                        if (msg_last_i) begin
                            if (w_tail_full) begin
                                r_pad_pend <= 1'b1;
                                r_p        <= 8'd0;
                            end else begin
                                r_p <= {r_wc, 3'b000} + {4'b0000, w_bytes};
                            end
                        end
                    end
                end
                ST_PAD: begin
                    r_buf      <= w_padded;
                    r_final    <= 1'b1;
                    r_pad_pend <= 1'b0;
                end
                ST_PERM: begin
                    if (!r_issued) begin
                        r_issued <= 1'b1;
                        r_first  <= 1'b0;
                    end
                    if (perm_done_i) begin
                        r_buf    <= '0;
                        r_wc     <= '0;
                        r_issued <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign block_o = r_buf;
    assign mode_o  = r_mode;

`ifdef SHA3_ABSORB_BLKCNT_EN
    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == ST_IDLE && start_i) begin
            r_cnt <= '0;
        end else if (r_state == ST_PERM && perm_done_i && r_cnt != '1) begin
            r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    assign blk_cnt_o = r_cnt;
`else
    assign blk_cnt_o = '0;
`endif

endmodule
